perf_counter_bank: RTL
======================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_EVENTS, default 14: number of event input lines; 1..64.
REQ-002 Parameter NUM_COUNTERS, default 2: number of independent counters; 1..16.
REQ-003 Parameter COUNTER_WIDTH, default 64: counter width in bits; 33..64.
REQ-004 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: reset, asynchronous, active-high.
REQ-006 Port perf_events  input  NUM_EVENTS: one pulse per cycle per event occurrence.
REQ-007 Port cr_write_en  input  1: register write strobe.
REQ-008 Port cr_read_en  input  1: register read strobe; mutually exclusive with cr_write_en.
REQ-009 Port cr_counter  input  4: target counter index.
REQ-010 Port cr_field  input  2: register select, perf_field_t (SELECT=0, COUNT_L=1, COUNT_H=2, CTRL=3).
REQ-011 Port cr_write_data  input  32: write value.
REQ-012 Port cr_read_data  output  32: read value, valid one cycle after cr_read_en.
REQ-013 Port overflow_irq  output  NUM_COUNTERS: per-counter registered interrupt request.

Function
REQ-014 Each counter SHALL own four fields:
- SELECT: event index, 6 bits.
- Counter value: COUNTER_WIDTH bits.
- CTRL: bit0 enable, bit1 irq_en, bit2 overflow (sticky).
- A 32-bit high-half shadow.
REQ-015 Counter SHALL increment by 1 in a cycle when enable=1 and perf_events[SELECT]=1.
REQ-016 SELECT >= NUM_EVENTS SHALL never increment the counter. Reads of SELECT return the written value.
REQ-017 An increment from all-ones SHALL wrap to 0 and set overflow in the same edge.
REQ-018 overflow_irq[i] SHALL be registered as overflow AND irq_en, asserted the cycle after the wrap edge.
REQ-019 Writing CTRL SHALL load enable and irq_en. Writing 1 to bit2 clears overflow; writing 0 leaves it unchanged.
REQ-020 Simultaneous overflow set and bit2 clear: set SHALL win.
REQ-021 Writing COUNT_L SHALL replace counter bits [31:0].
REQ-022 Writing COUNT_H SHALL replace bits [COUNTER_WIDTH-1:32]; excess write bits are ignored.
REQ-023 A counter write and an increment of the same counter in one cycle: the written value SHALL win and the increment is dropped.
REQ-024 Reading COUNT_L SHALL return bits [31:0] and latch bits [COUNTER_WIDTH-1:32], zero-extended, into the shadow in the same edge.
REQ-025 Reading COUNT_H SHALL return the shadow, so an L-then-H read pair is atomic.
REQ-026 Reading CTRL SHALL return {29'b0, overflow, irq_en, enable}.
REQ-027 cr_read_data SHALL be registered with 1-cycle latency and hold its value until the next read.
REQ-028 Access with cr_counter >= NUM_COUNTERS: writes SHALL be ignored and reads SHALL return 0.
REQ-029 Counters not addressed SHALL continue counting during any register access.

Reset
REQ-030 While reset is high, the following SHALL be 0:
- counters, SELECT, CTRL, shadows
- cr_read_data, overflow_irq
REQ-031 Reset asserted mid-count or mid-read SHALL abort the operation. The first edge after deassertion behaves as from the reset state.

Structure
REQ-032 perf_field_t and the CTRL bit positions SHALL be placed in the shared defines package.
REQ-033 NUM_EVENTS default SHALL equal CORE_PERF_EVENTS from the shared defines package.
REQ-034 One sub-module, perf_counter_slice, SHALL hold one counter's state and increment/overflow logic.
REQ-035 perf_counter_slice SHALL be instantiated NUM_COUNTERS times. The top level holds only address decode and the read mux.

Verification
REQ-036 Basic count: SELECT0=3, CTRL0=1; pulse event 3 for 10 cycles -> COUNT_L reads 10, COUNT_H reads 0.
REQ-037 Wrap and interrupt: COUNT_L=FFFFFFFF, COUNT_H=FFFFFFFF, CTRL0=3, one event -> counter 0, overflow_irq[0]=1 next cycle; CTRL write 4 -> irq clears.
REQ-038 Atomic read: counter=0x00000000_FFFFFFFF with event held high; read L then H -> H returns 0 even though counter now exceeds 2^32.
REQ-039 Write-versus-increment: write COUNT_L=0x55 while the event is active -> reads 0x55 the following cycle, not 0x56.
REQ-040 Boundaries: SELECT=63 with NUM_EVENTS=14 -> no count; cr_counter=5 with NUM_COUNTERS=2 -> read 0, write ignored.
REQ-041 Reset mid-run: assert reset while counting at 0x1234 -> all registers and outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/perf_counter_bank_pkg.sv
// Shared definitions for the performance counter bank: register field
// encoding, CTRL bit positions, the core event count and the field read helper.
package perf_counter_bank_pkg;

  // Number of performance event lines the core exports.
  localparam int CORE_PERF_EVENTS = 14;

  // Width of the SELECT field (event index).
  localparam int SEL_W = 6;

  // Register select encoding on the control port.
  typedef enum logic [1:0] {
    FIELD_SELECT  = 2'd0,
    FIELD_COUNT_L = 2'd1,
    FIELD_COUNT_H = 2'd2,
    FIELD_CTRL    = 2'd3
  } perf_field_t;

  // CTRL register bit positions.
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int CTRL_OVERFLOW_BIT = 2;

  // Value presented on a read of one counter's field. ctrl is packed as
  // {overflow, irq_en, enable}.
  function automatic logic [31:0] field_read(
    input perf_field_t      field,
    input logic [SEL_W-1:0] select,
    input logic [31:0]      count_lo,
    input logic [31:0]      shadow,
    input logic [2:0]       ctrl
  );
    logic [31:0] value;
    case (field)
      FIELD_SELECT:  value = {26'd0, select};
      FIELD_COUNT_L: value = count_lo;
      FIELD_COUNT_H: value = shadow;
      FIELD_CTRL:    value = {29'd0, ctrl};
      default:       value = 32'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/perf_counter_slice.sv
// One performance counter: event select, counter value, CTRL bits, read
// shadow of the upper half and the registered interrupt request.
module perf_counter_slice
  import perf_counter_bank_pkg::*;
#(
  parameter int NUM_EVENTS    = CORE_PERF_EVENTS,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] perf_events_i,
  input  logic                  sel_we_i,
  input  logic                  ctrl_we_i,
  input  logic                  cnt_l_we_i,
  input  logic                  cnt_h_we_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  shadow_latch_i,
  output logic [SEL_W-1:0]      select_o,
  output logic [31:0]           count_lo_o,
  output logic [2:0]            ctrl_o,
  output logic [31:0]           shadow_o,
  output logic                  irq_o
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  logic [SEL_W-1:0]         select_q, select_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     enable_q, enable_d;
  logic                     irq_en_q, irq_en_d;
  logic                     ovf_q, ovf_d;
  logic [31:0]              shadow_q, shadow_d;
  logic                     irq_q, irq_d;

  logic [63:0]              ev_pad_s;
  logic                     hit_s;
  logic                     wrap_s;

  // Zero-pad the event lines to the full SELECT range so that indices at or
  // above NUM_EVENTS always read as "no event".
  always_comb begin
    ev_pad_s                   = 64'd0;
    ev_pad_s[NUM_EVENTS-1:0]   = perf_events_i;
  end

  assign hit_s = enable_q & ev_pad_s[select_q];

  // Counter next state: a register write replaces the addressed half and
  // drops any increment in the same cycle; otherwise count the selected event.
  always_comb begin
    count_d = count_q;
    wrap_s  = 1'b0;
    if (cnt_l_we_i) begin
      count_d = {count_q[COUNTER_WIDTH-1:32], wr_data_i};
    end else if (cnt_h_we_i) begin
      count_d = {wr_data_i[COUNTER_WIDTH-33:0], count_q[31:0]};
    end else if (hit_s) begin
      count_d = count_q + CNT_ONE;
      wrap_s  = &count_q;
    end else begin
      count_d = count_q;
    end
  end

  // CTRL, SELECT, shadow and interrupt next state; a wrap beats a clear.
  always_comb begin
    enable_d = ctrl_we_i ? wr_data_i[CTRL_ENABLE_BIT] : enable_q;
    irq_en_d = ctrl_we_i ? wr_data_i[CTRL_IRQ_EN_BIT] : irq_en_q;
    select_d = sel_we_i ? wr_data_i[SEL_W-1:0] : select_q;
    shadow_d = shadow_latch_i ? 32'(count_q[COUNTER_WIDTH-1:32]) : shadow_q;
    if (wrap_s) begin
      ovf_d = 1'b1;
    end else if (ctrl_we_i && wr_data_i[CTRL_OVERFLOW_BIT]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    irq_d = ovf_d & irq_en_d;
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      select_q <= '0;
      count_q  <= '0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      shadow_q <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      select_q <= select_d;
      count_q  <= count_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      shadow_q <= shadow_d;
      irq_q    <= irq_d;
    end
  end

  assign select_o   = select_q;
  assign count_lo_o = count_q[31:0];
  assign ctrl_o     = {ovf_q, irq_en_q, enable_q};
  assign shadow_o   = shadow_q;
  assign irq_o      = irq_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of performance counters behind a small register port. This level only
// decodes register accesses and muxes read data; each counter is a slice.
module perf_counter_bank
  import perf_counter_bank_pkg::*;
#(
  parameter int NUM_EVENTS    = CORE_PERF_EVENTS,
  parameter int NUM_COUNTERS  = 2,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_EVENTS-1:0]   perf_events,
  input  logic                    cr_write_en,
  input  logic                    cr_read_en,
  input  logic [3:0]              cr_counter,
  input  logic [1:0]              cr_field,
  input  logic [31:0]             cr_write_data,
  output logic [31:0]             cr_read_data,
  output logic [NUM_COUNTERS-1:0] overflow_irq
);

  perf_field_t field_s;
  logic [31:0] field_val_s [NUM_COUNTERS];
  logic [31:0] rd_mux_s;
  logic [31:0] rd_data_q;

  assign field_s = perf_field_t'(cr_field);

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_slice
    logic             addr_hit_s;
    logic [SEL_W-1:0] select_s;
    logic [31:0]      count_lo_s;
    logic [2:0]       ctrl_s;
    logic [31:0]      shadow_s;

    assign addr_hit_s = (cr_counter == 4'(g));

    perf_counter_slice #(
      .NUM_EVENTS    (NUM_EVENTS),
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_slice (
      .clk            (clk),
      .reset          (reset),
      .perf_events_i  (perf_events),
      .sel_we_i       (cr_write_en & addr_hit_s & (field_s == FIELD_SELECT)),
      .ctrl_we_i      (cr_write_en & addr_hit_s & (field_s == FIELD_CTRL)),
      .cnt_l_we_i     (cr_write_en & addr_hit_s & (field_s == FIELD_COUNT_L)),
      .cnt_h_we_i     (cr_write_en & addr_hit_s & (field_s == FIELD_COUNT_H)),
      .wr_data_i      (cr_write_data),
      .shadow_latch_i (cr_read_en & addr_hit_s & (field_s == FIELD_COUNT_L)),
      .select_o       (select_s),
      .count_lo_o     (count_lo_s),
      .ctrl_o         (ctrl_s),
      .shadow_o       (shadow_s),
      .irq_o          (overflow_irq[g])
    );

    assign field_val_s[g] = field_read(field_s, select_s, count_lo_s, shadow_s, ctrl_s);
  end

  // Read mux: an index with no slice behind it matches nothing and reads 0.
  always_comb begin
    rd_mux_s = 32'd0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      rd_mux_s = rd_mux_s | ({32{cr_counter == 4'(i)}} & field_val_s[i]);
    end
  end

  // Read data register: captured on a read strobe, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= 32'd0;
    end else if (cr_read_en) begin
      rd_data_q <= rd_mux_s;
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign cr_read_data = rd_data_q;

endmodule
